cond_branch_resolver: RTL and testbench

Resolves Thumb conditional branches (format 16, `B<cond>`). It holds the architectural NZCV flag register, written by the ALU flag-update logic. It evaluates each branch's 4-bit condition against the current flags, forwarding a same-cycle flag write. It issues a one-cycle PC redirect plus a fixed-length pipeline flush when the branch is taken.

---
 rtl/thumb_pkg.sv | 37 +++
 rtl/cond_eval.sv | 40 ++++
 rtl/cond_branch_resolver.sv | 136 +++++++++++++
 tb/tb_cond_branch_resolver.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/thumb_pkg.sv
// Shared Thumb definitions: condition codes, NZCV bit positions and the branch resolver FSM.
package thumb_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int unsigned N_BIT = 3;
  localparam int unsigned Z_BIT = 2;
  localparam int unsigned C_BIT = 1;
  localparam int unsigned V_BIT = 0;

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    FLUSH
  } br_state_e;

  // Format-16 target: PC of the branch plus 4, plus the halfword offset; wraps modulo 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [7:0] offset);
    return pc + 32'd4 + {{23{offset[7]}}, offset, 1'b0};
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational Thumb condition evaluator: (cond, nzcv) -> pass.
module cond_eval
  import thumb_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[N_BIT];
  assign z = nzcv[Z_BIT];
  assign c = nzcv[C_BIT];
  assign v = nzcv[V_BIT];

  always_comb begin
    pass = 1'b0;
    unique case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_branch_resolver.sv
// Resolves Thumb B<cond>: holds NZCV, evaluates with same-cycle flag forwarding,
// and issues a registered PC redirect followed by a fixed-length flush.
module cond_branch_resolver
  import thumb_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [3:0]  RESET_NZCV   = 4'b0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flag_we,
  input  logic [3:0]  flag_in,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [3:0]  br_cond,
  input  logic [7:0]  br_offset,
  input  logic [31:0] br_pc,
  output logic [3:0]  nzcv,
  output logic        resolved,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        cond_err
);

  localparam int unsigned CntW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  br_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      nzcv_q;
  logic [3:0]      eff_nzcv;
  logic            cond_pass;
  logic            accept;
  logic            taken;

  logic            resolved_q, resolved_d;
  logic            cond_err_q, cond_err_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic            flush_q, flush_d;
  logic [31:0]     redirect_pc_q;

  // A flag write landing on the acceptance edge is visible to that branch.
  assign eff_nzcv = flag_we ? flag_in : nzcv_q;
  assign accept   = br_valid && br_ready;
  assign taken    = cond_pass;

  cond_eval u_cond_eval (
    .cond (br_cond),
    .nzcv (eff_nzcv),
    .pass (cond_pass)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzcv_q <= RESET_NZCV;
    end else if (flag_we) begin
      nzcv_q <= flag_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_pc_q <= 32'h0;
    end else if (accept) begin
      redirect_pc_q <= branch_target(br_pc, br_offset);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept && taken) begin
          state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        state_d = FLUSH;
        cnt_d   = CntW'(FLUSH_CYCLES - 1);
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs are derived from next state so they line up with the state they describe.
  always_comb begin
    br_ready         = (state_q == IDLE);
    resolved_d       = accept && !taken;
    cond_err_d       = accept && (br_cond == COND_NV);
    redirect_valid_d = (state_d == REDIRECT);
    flush_d          = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resolved_q       <= 1'b0;
      cond_err_q       <= 1'b0;
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
    end else begin
      resolved_q       <= resolved_d;
      cond_err_q       <= cond_err_d;
      redirect_valid_q <= redirect_valid_d;
      flush_q          <= flush_d;
    end
  end

  assign nzcv           = nzcv_q;
  assign resolved       = resolved_q;
  assign cond_err       = cond_err_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;

endmodule

// File: tb/tb_cond_branch_resolver.sv
// Directed bench for cond_branch_resolver; inputs driven and outputs sampled on the falling edge.
module tb_cond_branch_resolver;

  logic        clk;
  logic        rst_n;
  logic        flag_we;
  logic [3:0]  flag_in;
  logic        br_valid;
  logic        br_ready;
  logic [3:0]  br_cond;
  logic [7:0]  br_offset;
  logic [31:0] br_pc;
  logic [3:0]  nzcv;
  logic        resolved;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        cond_err;

  int errors;
  int checks;

  cond_branch_resolver #(
    .FLUSH_CYCLES (2),
    .RESET_NZCV   (4'b0100)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flag_we        (flag_we),
    .flag_in        (flag_in),
    .br_valid       (br_valid),
    .br_ready       (br_ready),
    .br_cond        (br_cond),
    .br_offset      (br_offset),
    .br_pc          (br_pc),
    .nzcv           (nzcv),
    .resolved       (resolved),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .cond_err       (cond_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a branch at a falling edge, let it be accepted, and return at the next falling edge.
  task automatic issue(input logic [3:0] cond, input logic [7:0] off, input logic [31:0] pc,
                       input logic we, input logic [3:0] fin);
    br_valid  = 1'b1;
    br_cond   = cond;
    br_offset = off;
    br_pc     = pc;
    flag_we   = we;
    flag_in   = fin;
    @(negedge clk);
    br_valid  = 1'b0;
    flag_we   = 1'b0;
  endtask

  task automatic write_flags(input logic [3:0] f);
    flag_we = 1'b1;
    flag_in = f;
    @(negedge clk);
    flag_we = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!br_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (nzcv !== 4'b0100 || flush !== 1'b0 || redirect_pc !== 32'h0 || br_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: nzcv=%b flush=%b rpc=%h ready=%b, required 0100 0 00000000 1",
               nzcv, flush, redirect_pc, br_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (br_ready !== 1'b1 || resolved !== 1'b0 || redirect_valid !== 1'b0 || cond_err !== 1'b0)
    begin
      errors++;
      $display("FAIL reset_release: ready=%b res=%b rv=%b err=%b, required 1 0 0 0",
               br_ready, resolved, redirect_valid, cond_err);
    end
  endtask

  task automatic test_beq();
    int fl, nr, rv;
    issue(4'h0, 8'h10, 32'h100, 1'b0, 4'h0);
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h124) begin
      errors++;
      $display("FAIL beq_redirect: rv=%b rpc=%h, required 1 00000124", redirect_valid, redirect_pc);
    end
    fl = 0; nr = 0; rv = 0;
    for (int i = 0; i < 8; i++) begin
      if (flush) fl++;
      if (!br_ready) nr++;
      if (redirect_valid) rv++;
      @(negedge clk);
    end
    checks++;
    if (fl != 3 || nr != 3 || rv != 1) begin
      errors++;
      $display("FAIL beq_flush_len: flush=%0d notready=%0d rv=%0d, required 3 3 1", fl, nr, rv);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    write_flags(4'b0000);
    checks++;
    if (nzcv !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_flags: nzcv=%b, required 0000", nzcv);
    end
    issue(4'h1, 8'h04, 32'h300, 1'b0, 4'h0);
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h30C) begin
      errors++;
      $display("FAIL bne_redirect: rv=%b rpc=%h, required 1 0000030c", redirect_valid, redirect_pc);
    end
    // BCC held pending while the resolver is busy.
    br_valid  = 1'b1;
    br_cond   = 4'h3;
    br_offset = 8'hFE;
    br_pc     = 32'h400;
    wait_ready(n);
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL bcc_holdoff: waited=%0d, required 3", n);
    end
    issue(4'h3, 8'hFE, 32'h400, 1'b0, 4'h0);
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h400) begin
      errors++;
      $display("FAIL bcc_redirect: rv=%b rpc=%h, required 1 00000400", redirect_valid, redirect_pc);
    end
    wait_ready(n);
    issue(4'h4, 8'h08, 32'h500, 1'b0, 4'h0);
    checks++;
    if (resolved !== 1'b1 || redirect_valid !== 1'b0 || flush !== 1'b0 || br_ready !== 1'b1) begin
      errors++;
      $display("FAIL bmi_resolved: res=%b rv=%b flush=%b ready=%b, required 1 0 0 1",
               resolved, redirect_valid, flush, br_ready);
    end
    @(negedge clk);
    checks++;
    if (resolved !== 1'b0) begin
      errors++;
      $display("FAIL bmi_pulse: res=%b, required 0", resolved);
    end
  endtask

  task automatic test_forwarding();
    int n;
    write_flags(4'b0000);
    issue(4'hA, 8'h00, 32'h500, 1'b1, 4'b1001);
    checks++;
    if (redirect_valid !== 1'b1 || nzcv !== 4'b1001 || redirect_pc !== 32'h504) begin
      errors++;
      $display("FAIL fwd_bge: rv=%b nzcv=%b rpc=%h, required 1 1001 00000504",
               redirect_valid, nzcv, redirect_pc);
    end
    write_flags(4'b0001);
    checks++;
    if (nzcv !== 4'b0001 || flush !== 1'b1 || redirect_pc !== 32'h504) begin
      errors++;
      $display("FAIL flag_write_in_flush: nzcv=%b flush=%b rpc=%h, required 0001 1 00000504",
               nzcv, flush, redirect_pc);
    end
    wait_ready(n);
    checks++;
    if (n >= 10) begin
      errors++;
      $display("FAIL fwd_ready_timeout: waited=%0d, required <10", n);
    end
    // Stored 0001 would take BLT; forwarded 1001 must not.
    issue(4'hB, 8'h00, 32'h600, 1'b1, 4'b1001);
    checks++;
    if (resolved !== 1'b1 || redirect_valid !== 1'b0 || nzcv !== 4'b1001) begin
      errors++;
      $display("FAIL fwd_blt: res=%b rv=%b nzcv=%b, required 1 0 1001", resolved, redirect_valid,
               nzcv);
    end
  endtask

  task automatic test_cond_table();
    logic [3:0] conds [16] = '{4'h8, 4'h8, 4'h9, 4'h9, 4'hC, 4'hC, 4'hD, 4'hD,
                               4'h2, 4'h6, 4'h7, 4'h5, 4'h0, 4'h4, 4'h3, 4'hA};
    logic [3:0] flags [16] = '{4'b0010, 4'b0110, 4'b0110, 4'b0010, 4'b0000, 4'b0100,
                               4'b1000, 4'b1001, 4'b0010, 4'b0001, 4'b0001, 4'b1000,
                               4'b0000, 4'b1000, 4'b0010, 4'b1000};
    logic       exp   [16] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                               1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int n;
    for (int i = 0; i < 16; i++) begin
      issue(conds[i], 8'h00, 32'h1000, 1'b1, flags[i]);
      checks++;
      if (redirect_valid !== exp[i] || resolved !== !exp[i]) begin
        errors++;
        $display("FAIL cond_%0d: cond=%h flags=%b rv=%b res=%b, required rv=%b", i, conds[i],
                 flags[i], redirect_valid, resolved, exp[i]);
      end
      wait_ready(n);
    end
  endtask

  task automatic test_wrap();
    int n;
    issue(4'hE, 8'h02, 32'hFFFF_FFFC, 1'b0, 4'h0);
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0004) begin
      errors++;
      $display("FAIL wrap_pos: rv=%b rpc=%h, required 1 00000004", redirect_valid, redirect_pc);
    end
    wait_ready(n);
    issue(4'hE, 8'h80, 32'h200, 1'b0, 4'h0);
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h104) begin
      errors++;
      $display("FAIL wrap_neg: rv=%b rpc=%h, required 1 00000104", redirect_valid, redirect_pc);
    end
    wait_ready(n);
  endtask

  task automatic test_cond_nv();
    issue(4'hF, 8'h10, 32'h700, 1'b0, 4'h0);
    checks++;
    if (cond_err !== 1'b1 || resolved !== 1'b1 || redirect_valid !== 1'b0 || flush !== 1'b0 ||
        br_ready !== 1'b1) begin
      errors++;
      $display("FAIL cond_nv: err=%b res=%b rv=%b flush=%b ready=%b, required 1 1 0 0 1",
               cond_err, resolved, redirect_valid, flush, br_ready);
    end
    @(negedge clk);
    checks++;
    if (cond_err !== 1'b0 || resolved !== 1'b0) begin
      errors++;
      $display("FAIL cond_nv_pulse: err=%b res=%b, required 0 0", cond_err, resolved);
    end
  endtask

  task automatic test_reset_mid_flush();
    issue(4'hE, 8'h00, 32'h800, 1'b0, 4'h0);
    write_flags(4'b1111);
    checks++;
    if (flush !== 1'b1 || br_ready !== 1'b0 || nzcv !== 4'b1111) begin
      errors++;
      $display("FAIL pre_reset_flush: flush=%b ready=%b nzcv=%b, required 1 0 1111", flush,
               br_ready, nzcv);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (flush !== 1'b0 || nzcv !== 4'b0100 || redirect_pc !== 32'h0 || br_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_flush: flush=%b nzcv=%b rpc=%h ready=%b, required 0 0100 0 1",
               flush, nzcv, redirect_pc, br_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (br_ready !== 1'b1 || flush !== 1'b0 || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: ready=%b flush=%b rv=%b, required 1 0 0", br_ready, flush,
               redirect_valid);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b1;
    flag_we   = 1'b0;
    flag_in   = 4'h0;
    br_valid  = 1'b0;
    br_cond   = 4'h0;
    br_offset = 8'h00;
    br_pc     = 32'h0;
    @(negedge clk);
    test_reset();
    test_beq();
    test_back_to_back();
    test_forwarding();
    test_cond_table();
    test_wrap();
    test_cond_nv();
    test_reset_mid_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
